// File: rtl/access_ctrl.sv
// Access-control sequencer for the door lock.
// Combines keypad PIN entry and RFID tags (one- or two-factor), enforces a
// retry limit with timed lockout, and runs the open/hold/close door cycle
// with obstacle reversal. Generates its own one-second tick from clk.
module access_ctrl #(
    parameter int                      PIN_DIGITS    = 4,
    parameter logic [4*PIN_DIGITS-1:0] PIN_CODE      = 16'h1234,
    parameter int                      TAG_W         = 8,
    parameter logic [TAG_W-1:0]        AUTH_TAG      = 8'hA5,
    parameter int                      TWO_FACTOR    = 1,
    parameter int                      MAX_TRIES     = 3,
    parameter int                      OPEN_SEC      = 5,
    parameter int                      DENY_SEC      = 2,
    parameter int                      LOCK_SEC      = 30,
    parameter int                      ENTRY_SEC     = 10,
    parameter int                      TICKS_PER_SEC = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    input  logic             tag_valid,
    input  logic [TAG_W-1:0] tag_id,
    input  logic             door_closed,
    input  logic             obstacle,
    output logic             mot_open,
    output logic             mot_close,
    output logic [3:0]       msg,
    output logic [3:0]       digits,
    output logic [3:0]       tries_left,
    output logic [2:0]       fsm_state
);

    localparam int BUF_W  = 4 * PIN_DIGITS;
    localparam int TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int SEC_W  = 16;

    typedef enum logic [2:0] {
        S_IDLE, S_ENTRY, S_CHECK, S_OPEN, S_CLOSING, S_DENIED, S_LOCKOUT
    } state_t;

    state_t             state, state_next;
    logic [BUF_W-1:0]   pin_buf;
    logic [3:0]         digit_cnt;
    logic [3:0]         tries;
    logic               tag_ok;
    logic [TICK_W-1:0]  tick_cnt;
    logic [SEC_W-1:0]   sec_cnt;

    // Event decode. Keys and tags only matter in IDLE/ENTRY; a tag in the
    // same cycle as a key wins and the key is dropped.
    logic accepting, tag_ev, tag_match, key_ev;
    logic is_digit, is_clear, is_enter, key_acc;
    logic check_pass, last_try, tick_last, timed_out;
    logic pass_ev, fail_ev, timer_clr;
    logic [SEC_W-1:0] hold_sec;

    assign accepting  = (state == S_IDLE) || (state == S_ENTRY);
    assign tag_ev     = tag_valid && accepting;
    assign tag_match  = (tag_id == AUTH_TAG);
    assign key_ev     = key_valid && accepting && !tag_valid;
    assign is_digit   = (key_code <= 4'd9);
    assign is_clear   = (key_code == 4'hA);
    assign is_enter   = (key_code == 4'hB);
    assign key_acc    = key_ev && (is_digit || is_clear || is_enter);
    assign check_pass = (digit_cnt == 4'(PIN_DIGITS)) && (pin_buf == PIN_CODE)
                        && (tag_ok || (TWO_FACTOR == 0));
    assign last_try   = (tries == 4'd1);
    assign tick_last  = (tick_cnt == TICK_W'(TICKS_PER_SEC - 1));
    assign timed_out  = tick_last && (sec_cnt == hold_sec - SEC_W'(1));
    assign pass_ev    = (state == S_CHECK) && check_pass;
    assign fail_ev    = ((state == S_CHECK) && !check_pass) || (tag_ev && !tag_match);
    assign timer_clr  = (state_next != state) ||
                        ((state == S_ENTRY) && (tag_ev || key_acc));

    // Hold time of the current state in seconds.
    always_comb begin
        hold_sec = SEC_W'(1);
        case (state)
            S_ENTRY:   hold_sec = SEC_W'(ENTRY_SEC);
            S_OPEN:    hold_sec = SEC_W'(OPEN_SEC);
            S_DENIED:  hold_sec = SEC_W'(DENY_SEC);
            S_LOCKOUT: hold_sec = SEC_W'(LOCK_SEC);
            default:   hold_sec = SEC_W'(1);
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_ENTRY: begin
                if (tag_ev) begin
                    if (tag_match) state_next = (TWO_FACTOR != 0) ? S_ENTRY : S_OPEN;
                    else           state_next = last_try ? S_LOCKOUT : S_DENIED;
                end else if (key_acc) begin
                    if (is_enter)      state_next = S_CHECK;
                    else if (is_digit) state_next = S_ENTRY;
                end else if ((state == S_ENTRY) && timed_out) begin
                    state_next = S_IDLE;
                end
            end
            S_CHECK: begin
                if (check_pass)    state_next = S_OPEN;
                else if (last_try) state_next = S_LOCKOUT;
                else               state_next = S_DENIED;
            end
            S_OPEN:    if (timed_out) state_next = S_CLOSING;
            S_CLOSING: begin
                if (obstacle)         state_next = S_OPEN;
                else if (door_closed) state_next = S_IDLE;
            end
            S_DENIED:  if (timed_out) state_next = S_IDLE;
            S_LOCKOUT: if (timed_out) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Datapath: second timer, retry counter, PIN buffer and tag flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            pin_buf   <= '0;
            digit_cnt <= '0;
            tag_ok    <= 1'b0;
            tries     <= 4'(MAX_TRIES);
            tick_cnt  <= '0;
            sec_cnt   <= '0;
        end else begin
            if (timer_clr) begin
                tick_cnt <= '0;
                sec_cnt  <= '0;
            end else if (tick_last) begin
                tick_cnt <= '0;
                sec_cnt  <= sec_cnt + SEC_W'(1);
            end else begin
                tick_cnt <= tick_cnt + TICK_W'(1);
            end

            if (pass_ev)
                tries <= 4'(MAX_TRIES);
            else if (fail_ev)
                tries <= tries - 4'd1;
            else if ((state == S_LOCKOUT) && (state_next == S_IDLE))
                tries <= 4'(MAX_TRIES);

            if ((state != S_IDLE) && (state_next == S_IDLE)) begin
                pin_buf   <= '0;
                digit_cnt <= '0;
                tag_ok    <= 1'b0;
            end else if (tag_ev && tag_match && (TWO_FACTOR != 0)) begin
                tag_ok <= 1'b1;
            end else if (key_acc && is_clear) begin
                pin_buf   <= '0;
                digit_cnt <= '0;
            end else if (key_acc && is_digit && (digit_cnt < 4'(PIN_DIGITS))) begin
                pin_buf   <= (pin_buf << 4) | BUF_W'(key_code);
                digit_cnt <= digit_cnt + 4'd1;
            end
        end
    end

    // Moore output decode.
    always_comb begin
        mot_open  = 1'b0;
        mot_close = 1'b0;
        msg       = 4'd0;
        case (state)
            S_IDLE:    msg = 4'd0;
            S_ENTRY,
            S_CHECK:   msg = tag_ok ? 4'd6 : 4'd1;
            S_OPEN:    begin mot_open = 1'b1;  msg = 4'd2; end
            S_CLOSING: begin mot_close = 1'b1; msg = 4'd5; end
            S_DENIED:  msg = 4'd3;
            S_LOCKOUT: msg = 4'd4;
            default:   msg = 4'd0;
        endcase
    end

    assign digits     = digit_cnt;
    assign tries_left = tries;
    assign fsm_state  = state;

endmodule

// File: tb/tb_access_ctrl.sv
// Directed bench for access_ctrl with a one-second tick of 10 cycles.
// Instance a is two-factor; instance b is single-factor and held in reset
// until its own step at the end.
module tb_access_ctrl;

    logic       clk = 1'b0;
    logic       rst_a = 1'b1;
    logic       rst_b = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic       tag_valid = 1'b0;
    logic [7:0] tag_id = 8'h00;
    logic       door_closed = 1'b0;
    logic       obstacle = 1'b0;

    logic       mot_open_a, mot_close_a, mot_open_b, mot_close_b;
    logic [3:0] msg_a, digits_a, tries_a, msg_b, digits_b, tries_b;
    logic [2:0] st_a, st_b;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];

    access_ctrl #(.TWO_FACTOR(1), .TICKS_PER_SEC(10)) dut_a (
        .clk(clk), .rst(rst_a), .key_valid(key_valid), .key_code(key_code),
        .tag_valid(tag_valid), .tag_id(tag_id), .door_closed(door_closed),
        .obstacle(obstacle), .mot_open(mot_open_a), .mot_close(mot_close_a),
        .msg(msg_a), .digits(digits_a), .tries_left(tries_a), .fsm_state(st_a)
    );

    access_ctrl #(.TWO_FACTOR(0), .TICKS_PER_SEC(10)) dut_b (
        .clk(clk), .rst(rst_b), .key_valid(key_valid), .key_code(key_code),
        .tag_valid(tag_valid), .tag_id(tag_id), .door_closed(door_closed),
        .obstacle(obstacle), .mot_open(mot_open_b), .mot_close(mot_close_b),
        .msg(msg_b), .digits(digits_b), .tries_left(tries_b), .fsm_state(st_b)
    );

    // Clock
    always #5 clk = ~clk;

    // Time limit
    initial begin
        #400_000;
        $display("FAIL timeout: bench did not finish, got running want done");
        $fatal(1, "timeout");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string name, input logic [15:0] obs);
        logic [15:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s: got %0h want <queue empty>", name, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s: got %0h want %0h", name, obs, e);
            end
        end
    endtask

    task automatic key(input logic [3:0] c);
        key_code  = c;
        key_valid = 1'b1;
        cyc(1);
        key_valid = 1'b0;
    endtask

    task automatic tag(input logic [7:0] id);
        tag_id    = id;
        tag_valid = 1'b1;
        cyc(1);
        tag_valid = 1'b0;
    endtask

    task automatic pin(input logic [3:0] d0, input logic [3:0] d1,
                       input logic [3:0] d2, input logic [3:0] d3);
        key(d0); key(d1); key(d2); key(d3);
    endtask

    task automatic reset_a();
        rst_a = 1'b1;
        cyc(2);
        rst_a = 1'b0;
    endtask

    initial begin
        int cnt;
        int dbad;

        // Reset state
        push(16'd0); push(16'd0); push(16'd0); push(16'd0); push(16'd3);
        reset_a();
        chk("rst_msg", 16'(msg_a));
        chk("rst_mot_open", 16'(mot_open_a));
        chk("rst_mot_close", 16'(mot_close_a));
        chk("rst_digits", 16'(digits_a));
        chk("rst_tries", 16'(tries_a));

        // Tag then correct PIN opens the door
        push(16'd6);
        tag(8'hA5);
        chk("tag_ok_msg", 16'(msg_a));
        push(16'd4);
        pin(4'd1, 4'd2, 4'd3, 4'd4);
        chk("pin_digits", 16'(digits_a));
        push(16'd0); push(16'd1); push(16'd2);
        key(4'hB);
        chk("check_not_open", 16'(mot_open_a));
        cyc(1);
        chk("open_mot", 16'(mot_open_a));
        chk("open_msg", 16'(msg_a));
        push(16'd50); push(16'd1); push(16'd5);
        cnt = 0;
        while (mot_open_a && cnt < 200) begin cyc(1); cnt++; end
        chk("open_hold", 16'(cnt));
        chk("closing_mot", 16'(mot_close_a));
        chk("closing_msg", 16'(msg_a));
        push(16'd0); push(16'd0);
        door_closed = 1'b1;
        cyc(1);
        door_closed = 1'b0;
        chk("closed_msg", 16'(msg_a));
        chk("closed_mot", 16'(mot_close_a));

        // Correct PIN without tag is denied
        push(16'd3); push(16'd2); push(16'd20); push(16'd0); push(16'd0);
        pin(4'd1, 4'd2, 4'd3, 4'd4);
        key(4'hB);
        cyc(1);
        chk("deny_msg", 16'(msg_a));
        chk("deny_tries", 16'(tries_a));
        cnt = 0;
        while (msg_a == 4'd3 && cnt < 200) begin cyc(1); cnt++; end
        chk("deny_len", 16'(cnt));
        chk("deny_end_msg", 16'(msg_a));
        chk("deny_end_digits", 16'(digits_a));

        // Three wrong attempts lead to lockout
        reset_a();
        push(16'd2); push(16'd1); push(16'd4); push(16'd0);
        for (int a = 0; a < 3; a++) begin
            pin(4'd9, 4'd9, 4'd9, 4'd9);
            key(4'hB);
            cyc(1);
            if (a < 2) begin
                chk("wrong_tries", 16'(tries_a));
                cyc(20);
            end
        end
        chk("lock_msg", 16'(msg_a));
        chk("lock_tries", 16'(tries_a));
        push(16'd300); push(16'd0); push(16'd0); push(16'd3); push(16'd0);
        cnt = 0;
        dbad = 0;
        key_code = 4'hA;
        while (msg_a == 4'd4 && cnt < 1000) begin
            key_valid = (cnt % 7 == 0);
            cyc(1);
            cnt++;
            if (msg_a == 4'd4 && digits_a != 4'd4) dbad++;
        end
        key_valid = 1'b0;
        chk("lock_len", 16'(cnt));
        chk("lock_keys_ignored", 16'(dbad));
        chk("lock_end_msg", 16'(msg_a));
        chk("lock_end_tries", 16'(tries_a));
        chk("lock_end_digits", 16'(digits_a));

        // Obstacle during closing reopens; obstacle beats door_closed
        tag(8'hA5);
        pin(4'd1, 4'd2, 4'd3, 4'd4);
        key(4'hB);
        cyc(1);
        cyc(50);
        push(16'd1);
        chk("obs_closing", 16'(mot_close_a));
        push(16'd1); push(16'd0); push(16'd2);
        obstacle    = 1'b1;
        door_closed = 1'b1;
        cyc(1);
        obstacle    = 1'b0;
        door_closed = 1'b0;
        chk("obs_reopen", 16'(mot_open_a));
        chk("obs_no_close", 16'(mot_close_a));
        chk("obs_msg", 16'(msg_a));
        push(16'd50); push(16'd1);
        cnt = 0;
        while (mot_open_a && cnt < 200) begin cyc(1); cnt++; end
        chk("obs_hold", 16'(cnt));
        chk("obs_closing2", 16'(mot_close_a));
        push(16'd0);
        door_closed = 1'b1;
        cyc(1);
        door_closed = 1'b0;
        chk("obs_idle", 16'(msg_a));

        // Entry inactivity timeout
        push(16'd2); push(16'd1); push(16'd0); push(16'd0); push(16'd3);
        key(4'd1);
        key(4'd2);
        chk("to_digits", 16'(digits_a));
        cyc(99);
        chk("to_still_entry", 16'(msg_a));
        cyc(1);
        chk("to_msg", 16'(msg_a));
        chk("to_digits0", 16'(digits_a));
        chk("to_tries", 16'(tries_a));

        // Key and tag in the same cycle: tag wins
        push(16'd6); push(16'd0);
        key_code  = 4'd5;
        key_valid = 1'b1;
        tag_id    = 8'hA5;
        tag_valid = 1'b1;
        cyc(1);
        key_valid = 1'b0;
        tag_valid = 1'b0;
        chk("both_msg", 16'(msg_a));
        chk("both_digits", 16'(digits_a));

        // Wrong tag counts as a failed attempt
        push(16'd3); push(16'd2); push(16'd0);
        tag(8'h3C);
        cyc(1);
        chk("badtag_msg", 16'(msg_a));
        chk("badtag_tries", 16'(tries_a));
        cyc(25);
        chk("badtag_idle", 16'(msg_a));

        // Single-factor instance: tag alone opens; reset drops the motor
        rst_b = 1'b0;
        cyc(1);
        push(16'd0); push(16'd3);
        chk("b_rst_msg", 16'(msg_b));
        chk("b_rst_tries", 16'(tries_b));
        push(16'd1); push(16'd2);
        tag(8'hA5);
        chk("b_open_mot", 16'(mot_open_b));
        chk("b_open_msg", 16'(msg_b));
        cyc(3);
        push(16'd0); push(16'd0);
        rst_b = 1'b1;
        cyc(1);
        chk("b_rst_open_mot", 16'(mot_open_b));
        chk("b_rst_open_msg", 16'(msg_b));
        rst_b = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/access_ctrl.md
# access_ctrl

Parametrised access-control sequencer for the door-lock design. It combines keypad PIN entry and RFID tag presentation, with single- or two-factor mode, a retry limit with timed lockout, and an open/hold/close door cycle with obstacle reversal. It drives the door motor lines and the LCD message code. It replaces the fixed 1 Hz state machine: it runs on the system clock and generates its own second tick.

## Interface
Parameters:
- PIN_DIGITS, 4, number of PIN digits
- PIN_CODE, 16'h1234, expected PIN as 4-bit BCD digits, most-significant digit first, width 4*PIN_DIGITS
- TAG_W, 8, RFID tag width
- AUTH_TAG, 8'hA5, authorised tag value
- TWO_FACTOR, 1, 1 = tag AND PIN required; 0 = tag OR PIN
- MAX_TRIES, 3, failures before lockout (1..15)
- OPEN_SEC, 5, door hold time in seconds
- DENY_SEC, 2, denied message time in seconds
- LOCK_SEC, 30, lockout time in seconds
- ENTRY_SEC, 10, inactivity timeout during entry, in seconds
- TICKS_PER_SEC, 50_000_000, clk cycles per second

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- key_valid  in  1  one-cycle strobe from the keypad scanner
- key_code  in  4  0–9 = digit, 0xA = clear, 0xB = enter, 0xC–0xF ignored
- tag_valid  in  1  one-cycle strobe, tag received
- tag_id  in  TAG_W  received tag
- door_closed  in  1  limit switch, 1 = fully closed
- obstacle  in  1  1 = obstruction in the doorway
- mot_open  out  1  open motor drive
- mot_close  out  1  close motor drive; never high together with mot_open
- msg  out  4  LCD code: 0 idle, 1 entering, 2 granted, 3 denied, 4 locked, 5 closing, 6 tag accepted/await PIN
- digits  out  4  count of buffered digits
- tries_left  out  4  remaining attempts

## Operation
States:
- IDLE: msg 0.
- ENTRY: msg 1, or msg 6 if tag_ok is set.
- CHECK: transient, one cycle.
- OPEN: mot_open=1, msg 2.
- CLOSING: mot_close=1, msg 5.
- DENIED: msg 3.
- LOCKOUT: msg 4.

Keys (IDLE or ENTRY only; ignored in all other states):
- Digit: appended to the buffer. Moves IDLE→ENTRY. Digits beyond PIN_DIGITS are dropped and digits saturates.
- Clear: empties the buffer and keeps tag_ok.
- Enter: moves to CHECK.

Tags (IDLE or ENTRY only):
- tag_id==AUTH_TAG, TWO_FACTOR=0: go to OPEN.
- tag_id==AUTH_TAG, TWO_FACTOR=1: set tag_ok and go to ENTRY.
- Mismatch: counts as a failure and takes the CHECK-fail path.

CHECK passes when all of these hold:
- digits==PIN_DIGITS
- buffer==PIN_CODE
- tag_ok is set, or TWO_FACTOR=0

CHECK outcome:
- Pass: go to OPEN and set tries_left=MAX_TRIES.
- Fail: decrement tries_left. If it reaches 0, go to LOCKOUT; otherwise go to DENIED.

State exits:
- OPEN→CLOSING after OPEN_SEC seconds.
- CLOSING→IDLE when door_closed=1.
- CLOSING→OPEN when obstacle=1; the OPEN timer restarts. obstacle takes priority over door_closed.
- DENIED→IDLE after DENY_SEC seconds.
- LOCKOUT→IDLE after LOCK_SEC seconds; tries_left is restored to MAX_TRIES.
- ENTRY→IDLE after ENTRY_SEC seconds without a key or tag. No try is consumed.

Every return to IDLE clears the buffer, digits and tag_ok.

If key_valid and tag_valid arrive in the same cycle, the tag is processed and the key is dropped.

## Timing
- Reset (edge with rst=1): state IDLE, mot_open=0, mot_close=0, msg=0, digits=0, tries_left=MAX_TRIES, tick counter=0. Reset in OPEN or CLOSING drops the motor drive at that edge.
- All outputs are Moore outputs decoded from registered state and counters.
- Enter strobe sampled at edge k: state is CHECK after edge k, and the result state (OPEN/DENIED/LOCKOUT) is visible after edge k+1.
- A digit strobe at edge k shows in digits after edge k.
- Second timer: the cycle counter and the seconds counter clear on every state change and on every accepted key or tag in ENTRY. A state timed for N seconds exits exactly N*TICKS_PER_SEC cycles after entry.
- Strobes in states that ignore them have no effect. Strobes are not queued.

## Test plan
Bench parameters: TICKS_PER_SEC=10, TWO_FACTOR=1 unless stated.
- Tag 0xA5, then keys 1,2,3,4,B → msg 6 after the tag. OPEN appears 2 cycles after B with mot_open=1 for exactly 50 cycles, then CLOSING. Asserting door_closed gives IDLE, msg 0.
- Keys 1,2,3,4,B with no tag → DENIED, tries_left 2, msg 3 for 20 cycles, then IDLE.
- Three wrong attempts (9,9,9,9,B) → tries_left goes 2, 1, 0, then LOCKOUT msg 4 for 300 cycles with all keys ignored. Ends in IDLE with tries_left 3.
- During CLOSING pulse obstacle → back to OPEN with mot_close=0, mot_open=1 the next cycle, and a full 50-cycle hold.
- Keys 1,2 then idle 100 cycles → IDLE, digits 0, tries_left unchanged. Also: key_valid and tag_valid in the same cycle → only the tag is accepted.
- TWO_FACTOR=0: tag 0xA5 alone opens the door. rst asserted during OPEN → mot_open=0 and msg 0 after that edge.
